// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the mux4_rr_arbiter slice.
//   N_REQ / SEL_W  : number of requesters and width of a lane index
//   obuf_state_t   : output register occupancy (EMPTY / FULL)
//   ptr_add()      : lane index arithmetic modulo N_REQ
package mux4_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } obuf_state_t;

  // Index arithmetic wraps naturally because the result is SEL_W bits wide.
  function automatic logic [SEL_W-1:0] ptr_add(input logic [SEL_W-1:0] p,
                                                input logic [SEL_W-1:0] k);
    return p + k;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4_cell.sv
// Single-bit 4:1 mux cell used to build the shared word-wide datapath.
//   d   : the four candidate bits, d[i] from lane i
//   sel : lane select
//   y   : selected bit
module mux4_cell (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);

  assign y = d[sel];

endmodule

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin winner search over four requesters.
//   req     : per-lane request bits
//   ptr     : index of the most recently granted lane
//   winner  : first requesting lane in order ptr+1, ptr+2, ptr+3, ptr (mod 4)
//   any_req : at least one lane is requesting
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any_req
);

  logic             found;
  logic [SEL_W-1:0] cand;

  assign any_req = |req;

  // k runs 1..4; k=4 truncates to 0, so the last lane examined is ptr itself.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr_add(ptr, k[SEL_W-1:0]);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 word mux between four requesters and
// capturing the winning word into a valid/ready output register.
//   clk, rst   : clock, asynchronous active-high reset
//   req, data  : per-lane request and word (lane i at data[i*WIDTH +: WIDTH])
//   gnt        : one-hot, combinational; lane captured at this edge
//   out_valid, out_ready, out_data, out_src : downstream handshake and payload
//   busy       : mirrors out_valid
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       gnt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_src,
  output logic                   busy
);

  obuf_state_t      state_reg, state_next;
  logic [SEL_W-1:0] ptr_reg;
  logic [WIDTH-1:0] data_reg;
  logic [SEL_W-1:0] src_reg;

  logic [SEL_W-1:0] winner;
  logic             any_req;
  logic             load;
  logic             capture;
  logic [WIDTH-1:0] mux_word;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr_reg),
    .winner  (winner),
    .any_req (any_req)
  );

  // Bit-sliced shared datapath steered directly by the combinational winner.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
      mux4_cell u_cell (
        .d   ({data[3*WIDTH+gi], data[2*WIDTH+gi], data[WIDTH+gi], data[gi]}),
        .sel (winner),
        .y   (mux_word[gi])
      );
    end
  endgenerate

  assign load    = (state_reg == EMPTY) || out_ready;
  assign capture = load && any_req;

  // Next state plus grant. gnt is forced low while rst is held because the
  // register reads EMPTY during reset and would otherwise show a grant.
  always_comb begin
    state_next = state_reg;
    gnt        = '0;
    if (load) begin
      state_next = any_req ? FULL : EMPTY;
    end
    if (capture && !rst) begin
      gnt[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      ptr_reg   <= SEL_W'(N_REQ - 1);
      data_reg  <= '0;
      src_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // Payload and pointer only move on a capture; a drain leaves them alone.
      if (capture) begin
        data_reg <= mux_word;
        src_reg  <= winner;
        ptr_reg  <= winner;
      end
    end
  end

  assign out_valid = (state_reg == FULL);
  assign busy      = out_valid;
  assign out_data  = data_reg;
  assign out_src   = src_reg;

endmodule
